// File: rtl/seq_det_pkg.sv
// Shared constants for the programmable sequence detector.
// Output-mode encodings and a constant clog2 for parameter checks.
package seq_det_pkg;

  localparam logic MODE_MEALY = 1'b0;
  localparam logic MODE_MOORE = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Longest pattern-prefix search over the candidate window.
// In: w, wv, pat_r, len_r. Out: next_q, full_match.
module seq_prefix_match #(
  parameter int N  = 8,
  parameter int LW = 4
) (
  input  logic [N-1:0]  w,
  input  logic [LW-1:0] wv,
  input  logic [N-1:0]  pat_r,
  input  logic [LW-1:0] len_r,
  output logic [LW-1:0] next_q,
  output logic          full_match
);

  localparam logic [N-1:0] ONES = '1;

  // The first k pattern bits sit at pat_r[len_r-1 -: k];
  // shifting them down lets one masked compare test w[k-1:0].
  // Ascending k with overwrite leaves the longest hit.
  always_comb begin
    next_q = '0;
    for (int k = 1; k <= N; k++) begin
      if (k <= int'(len_r) && k <= int'(wv)) begin
        if (((w ^ (pat_r >> (int'(len_r) - k)))
             & (ONES >> (N - k))) == '0)
          next_q = LW'(k);
      end
    end
    full_match = (len_r != '0) && (next_q == len_r);
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial sequence detector with counter.
// In: clk reset X M OV load pat len. Out: Z Q match_cnt.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             N           = 8,
  parameter int             LW          = 4,
  parameter int             CNT_W       = 8,
  parameter logic [N-1:0]   DEFAULT_PAT = 'b0000_1011,
  parameter int             DEFAULT_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             X,
  input  logic             M,
  input  logic             OV,
  input  logic             load,
  input  logic [N-1:0]     pat,
  input  logic [LW-1:0]    len,
  output logic             Z,
  output logic [LW-1:0]    Q,
  output logic [CNT_W-1:0] match_cnt
);

  if (N < 2 || clog2(N + 1) > LW) begin : g_bad_param
    $error("seq_detector_param: need N>=2 and 2**LW > N");
  end

  logic [N-1:0]  pat_r;
  logic [LW-1:0] len_r;
  // Only N-1 history bits are ever read; the oldest falls off.
  logic [N-2:0]  h;
  logic [LW-1:0] vcnt;
  logic [LW-1:0] q;
  logic          zm;

  logic [N-1:0]  w;
  logic [LW-1:0] wv;
  logic [LW-1:0] next_q;
  logic          full_match;

  assign w  = {h, X};
  assign wv = (vcnt == LW'(N)) ? LW'(N) : vcnt + LW'(1);

  seq_prefix_match #(
    .N  (N),
    .LW (LW)
  ) u_match (
    .w          (w),
    .wv         (wv),
    .pat_r      (pat_r),
    .len_r      (len_r),
    .next_q     (next_q),
    .full_match (full_match)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_r     <= DEFAULT_PAT;
      len_r     <= LW'(DEFAULT_LEN);
      h         <= '0;
      vcnt      <= '0;
      q         <= '0;
      zm        <= 1'b0;
      match_cnt <= '0;
    end else if (load) begin
      pat_r     <= pat;
      len_r     <= (len > LW'(N)) ? LW'(N) : len;
      h         <= '0;
      vcnt      <= '0;
      q         <= '0;
      zm        <= 1'b0;
      match_cnt <= '0;
    end else begin
      h  <= w[N-2:0];
      q  <= next_q;
      zm <= full_match;
      if (full_match && match_cnt != '1)
        match_cnt <= match_cnt + CNT_W'(1);
      // Non-overlap: forget the matched bits, keep shifting.
      vcnt <= (full_match && !OV) ? '0 : wv;
    end
  end

  assign Q = q;
  assign Z = reset ? 1'b0
           : (M == MODE_MOORE) ? zm : full_match;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: vector table, corners, random.
// Reference model keeps bit queues in arrival order.
module tb_seq_detector_param;

  localparam int N  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          X, M, OV, load;
  logic [N-1:0]  pat;
  logic [LW-1:0] len;
  logic          Z, Zs;
  logic [LW-1:0] Q, Qs;
  logic [7:0]    cnt;
  logic [1:0]    cnts;

  always #5 clk = ~clk;

  seq_detector_param #(.N(N), .LW(LW), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .X(X), .M(M), .OV(OV),
    .load(load), .pat(pat), .len(len),
    .Z(Z), .Q(Q), .match_cnt(cnt)
  );

  seq_detector_param #(.N(N), .LW(LW), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .X(X), .M(M), .OV(OV),
    .load(load), .pat(pat), .len(len),
    .Z(Zs), .Q(Qs), .match_cnt(cnts)
  );

  int ncmp = 0;
  int nerr = 0;

  bit mh[$];
  bit mp[$];
  int mlen;
  int mq;
  bit mzm;
  int mcnt;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    mp = '{1'b1, 1'b0, 1'b1, 1'b1};
    mlen = 4;
    mh.delete();
    mq = 0;
    mzm = 1'b0;
    mcnt = 0;
  endtask

  task automatic m_load(input logic [N-1:0] p, input int l);
    int ll;
    ll = imin(l, N);
    mp.delete();
    for (int i = ll - 1; i >= 0; i--) mp.push_back(p[i]);
    mlen = ll;
    mh.delete();
    mq = 0;
    mzm = 1'b0;
    mcnt = 0;
  endtask

  // Candidate = retained bits plus x; longest tail equal to a
  // pattern prefix gives progress, full length gives a match.
  task automatic m_eval(input bit x, output bit fm, output int nq);
    bit c[$];
    bit ok;
    c = mh;
    c.push_back(x);
    if (c.size() > N) void'(c.pop_front());
    nq = 0;
    for (int k = 1; k <= mlen; k++) begin
      if (c.size() >= k) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (c[c.size() - k + i] != mp[i]) ok = 1'b0;
        if (ok) nq = k;
      end
    end
    fm = (mlen != 0) && (nq == mlen);
  endtask

  task automatic m_step(input bit x, input bit fm, input int nq);
    if (fm && !OV) begin
      mh.delete();
    end else begin
      mh.push_back(x);
      if (mh.size() > N) void'(mh.pop_front());
    end
    mq = nq;
    mzm = fm;
    mcnt += int'(fm);
  endtask

  task automatic drive(input bit x, output bit zpre);
    bit fm;
    int nq;
    X = x;
    #1;
    m_eval(x, fm, nq);
    zpre = Z;
    chk("z", Z, M ? mzm : fm);
    chk("z_sat", Zs, M ? mzm : fm);
    @(posedge clk);
    m_step(x, fm, nq);
    #1;
    chk("q", Q, mq);
    chk("cnt", cnt, imin(mcnt, 255));
    chk("cnt_sat", cnts, imin(mcnt, 3));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
  endtask

  task automatic do_load(input logic [N-1:0] p, input int l);
    pat = p;
    len = LW'(l);
    load = 1'b1;
    @(posedge clk);
    m_load(p, l);
    #1;
    load = 1'b0;
    chk("load_q", Q, 0);
    chk("load_cnt", cnt, 0);
  endtask

  typedef struct {
    bit x;
    bit exp_z;
    int exp_q;
    int exp_cnt;
  } vec_t;

  vec_t tv[14];
  int   sat_exp[6];
  bit   z;

  initial begin
    // rows 0..6: Mealy, overlap; rows 7..13: Moore, no overlap
    tv[0]  = '{1'b1, 1'b0, 1, 0};
    tv[1]  = '{1'b0, 1'b0, 2, 0};
    tv[2]  = '{1'b1, 1'b0, 3, 0};
    tv[3]  = '{1'b1, 1'b1, 4, 1};
    tv[4]  = '{1'b0, 1'b0, 2, 1};
    tv[5]  = '{1'b1, 1'b0, 3, 1};
    tv[6]  = '{1'b1, 1'b1, 4, 2};
    tv[7]  = '{1'b1, 1'b0, 1, 0};
    tv[8]  = '{1'b0, 1'b0, 2, 0};
    tv[9]  = '{1'b1, 1'b0, 3, 0};
    tv[10] = '{1'b1, 1'b0, 4, 1};
    tv[11] = '{1'b0, 1'b1, 0, 1};
    tv[12] = '{1'b1, 1'b0, 1, 1};
    tv[13] = '{1'b1, 1'b0, 1, 1};
    sat_exp = '{1, 2, 3, 3, 3, 3};

    reset = 1'b1;
    X = 1'b1;
    M = 1'b0;
    OV = 1'b1;
    load = 1'b0;
    pat = '0;
    len = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", Q, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_z_mealy", Z, 0);
    M = 1'b1;
    #1;
    chk("rst_z_moore", Z, 0);
    reset = 1'b0;
    X = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin
        M = 1'b0;
        OV = 1'b1;
      end
      if (i == 7) begin
        do_reset();
        M = 1'b1;
        OV = 1'b0;
      end
      drive(tv[i].x, z);
      chk($sformatf("tv%0d_z", i), z, tv[i].exp_z);
      chk($sformatf("tv%0d_q", i), Q, tv[i].exp_q);
      chk($sformatf("tv%0d_cnt", i), cnt, tv[i].exp_cnt);
    end

    // all-ones pattern, full length, both overlap policies
    M = 1'b0;
    OV = 1'b1;
    do_load(8'hFF, 8);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, z);
      chk($sformatf("ones_ov_z%0d", i), z, i >= 7);
    end
    chk("ones_ov_cnt", cnt, 3);
    OV = 1'b0;
    do_load(8'hFF, 8);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, z);
      chk($sformatf("ones_nov_z%0d", i), z, i == 7);
    end
    chk("ones_nov_cnt", cnt, 1);

    // async reset mid-pattern, then default pattern is back
    OV = 1'b1;
    do_load(8'hFF, 8);
    repeat (8) drive(1'b1, z);
    drive(1'b1, z);
    drive(1'b0, z);
    drive(1'b1, z);
    chk("pre_rst_cnt", cnt, 2);
    X = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("async_q", Q, 0);
    chk("async_z", Z, 0);
    chk("async_cnt", cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
    drive(1'b1, z);
    drive(1'b0, z);
    drive(1'b1, z);
    drive(1'b1, z);
    chk("dflt_z", z, 1);
    chk("dflt_cnt", cnt, 1);

    // disabled detector
    do_load(8'h0B, 0);
    drive(1'b1, z);
    drive(1'b0, z);
    drive(1'b1, z);
    drive(1'b1, z);
    chk("len0_z", z, 0);
    chk("len0_q", Q, 0);
    chk("len0_cnt", cnt, 0);

    // oversize length clamps to N
    do_load(8'hFF, 15);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, z);
      chk($sformatf("clamp_z%0d", i), z, i == 7);
    end
    chk("clamp_q", Q, 8);
    chk("clamp_cnt", cnt, 1);

    // 2-bit counter saturation
    do_load(8'h01, 1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, z);
      chk($sformatf("sat%0d", i), cnts, sat_exp[i]);
    end

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        if ($urandom_range(0, 4) == 0)
          do_load(N'($urandom), $urandom_range(0, 15));
        else
          do_load(N'($urandom), $urandom_range(1, 4));
      end
      if ($urandom_range(0, 19) == 0) OV = ~OV;
      M = $urandom_range(0, 1);
      drive($urandom_range(0, 1) == 1, z);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
